// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch buffer.
// The entry record carries one fetched instruction and its PC values.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_entry_t;

    // addi x0, x0, 0 -- shown to decode whenever no entry is valid
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/fetch_buffer_mem.sv
// Storage array for the fetch buffer: one write port, one async read port.
// Contents are deliberately left unreset; only pushed slots are ever read.
module fetch_buffer_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  fetch_entry_t             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output fetch_entry_t             rd_data
);

    fetch_entry_t mem_q [DEPTH];

    // Capture the incoming entry into the addressed slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode circular FIFO with synchronous flush for taken branches.
// Optional feature: define FETCH_BUFFER_BYPASS_EN to let an entry arriving
// at an empty buffer reach decode in the same cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_pc_plus4,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc_plus4,
    output logic [31:0]            out_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    fetch_entry_t  in_entry;
    fetch_entry_t  head_entry;
    logic          stored_valid;
    logic          bypass_hit;
    logic          push;
    logic          pop;
    logic          mem_write;
    logic          mem_read;

    assign in_entry = '{pc: in_pc, pc_plus4: in_pc_plus4, instr: in_instr};

    // A stored head is presentable only outside reset and flush
    assign stored_valid = reset && !flush && (count_q != '0);

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass_hit = reset && !flush && in_valid && (count_q == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign in_ready  = reset && !flush && (count_q < FULL_COUNT);
    assign out_valid = stored_valid || bypass_hit;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A bypassed entry consumed straight away never occupies a slot
    assign mem_write = push && !(bypass_hit && out_ready);
    assign mem_read  = pop && stored_valid;
    assign count     = count_q;

    fetch_buffer_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (mem_write),
        .wr_addr(wr_ptr),
        .wr_data(in_entry),
        .rd_addr(rd_ptr),
        .rd_data(head_entry)
    );

    // Select what decode sees: bypassed input, stored head, or a NOP bubble
    always_comb begin
        out_pc       = '0;
        out_pc_plus4 = '0;
        out_instr    = NOP_INSTR;
        if (bypass_hit) begin
            out_pc       = in_entry.pc;
            out_pc_plus4 = in_entry.pc_plus4;
            out_instr    = in_entry.instr;
        end else if (stored_valid) begin
            out_pc       = head_entry.pc;
            out_pc_plus4 = head_entry.pc_plus4;
            out_instr    = head_entry.instr;
        end
    end

    // Advance pointers and occupancy; flush empties the buffer outright
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (mem_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (mem_read) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({mem_write, mem_read})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer: directed table, corner sequences, and a
// randomized run against a queue-based model of the buffer's behaviour.
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [$clog2(DEPTH):0] count;

    int vectors = 0;
    int miscompares = 0;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_pc_plus4 (in_pc_plus4),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_pc_plus4(out_pc_plus4),
        .out_instr   (out_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [31:0] pc;
        logic        chk_valid;
        logic        chk_pc;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_pc;
        int          exp_count;
    } vec_t;

    vec_t vecs [18];
    fetch_entry_t model_q [$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic fl, input logic iv, input logic ordy,
                                 input logic [31:0] pc, input logic [31:0] instr);
        flush       = fl;
        in_valid    = iv;
        out_ready   = ordy;
        in_pc       = pc;
        in_pc_plus4 = pc + 32'd4;
        in_instr    = instr;
    endtask

    initial begin
        int   qsize;
        logic bhit;
        logic exp_ir;
        logic exp_ov;
        fetch_entry_t inc;

        // flush iv or pc chk_v chk_pc ir ov out_pc count
        vecs[0]  = '{0, 1, 0, 32'h100, 1, 0, 1, BYPASS, 32'h0,   0};
        vecs[1]  = '{0, 1, 0, 32'h104, 1, 1, 1, 1, 32'h100, 1};
        vecs[2]  = '{0, 1, 0, 32'h108, 1, 1, 1, 1, 32'h100, 2};
        vecs[3]  = '{0, 1, 0, 32'h10C, 1, 1, 1, 1, 32'h100, 3};
        vecs[4]  = '{0, 1, 0, 32'h110, 1, 1, 0, 1, 32'h100, 4};
        vecs[5]  = '{0, 0, 1, 32'h0,   1, 1, 0, 1, 32'h100, 4};
        vecs[6]  = '{0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h104, 3};
        vecs[7]  = '{0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h104, 3};
        vecs[8]  = '{0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h108, 2};
        vecs[9]  = '{0, 0, 1, 32'h0,   1, 1, 1, 1, 32'h10C, 1};
        vecs[10] = '{0, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   0};
        vecs[11] = '{0, 1, 0, 32'h200, 1, 0, 1, BYPASS, 32'h0, 0};
        vecs[12] = '{0, 1, 0, 32'h204, 1, 1, 1, 1, 32'h200, 1};
        vecs[13] = '{0, 1, 1, 32'h208, 1, 1, 1, 1, 32'h200, 2};
        vecs[14] = '{0, 0, 0, 32'h0,   1, 1, 1, 1, 32'h204, 2};
        vecs[15] = '{1, 1, 1, 32'h20C, 1, 0, 0, 0, 32'h0,   2};
        vecs[16] = '{0, 0, 0, 32'h0,   1, 1, 1, 0, 32'h0,   0};
        vecs[17] = '{0, 0, 1, 32'h0,   1, 1, 1, 0, 32'h0,   0};

        // Reset values while held in reset
        applyStimulus(0, 1, 0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_instr", out_instr, NOP_INSTR);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0);

        // Directed table: fill, full, drain, push+pop, flush
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready,
                          vecs[i].pc, vecs[i].pc ^ 32'hA5A50000);
            #1;
            checkOutput($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
            if (vecs[i].chk_valid)
                checkOutput($sformatf("tbl%0d_out_valid", i), 32'(out_valid),
                            32'(vecs[i].exp_out_valid));
            if (vecs[i].chk_pc && vecs[i].exp_out_valid) begin
                checkOutput($sformatf("tbl%0d_out_pc", i), out_pc, vecs[i].exp_out_pc);
                checkOutput($sformatf("tbl%0d_out_instr", i), out_instr,
                            vecs[i].exp_out_pc ^ 32'hA5A50000);
            end else if (vecs[i].chk_pc && vecs[i].exp_count == 0) begin
                checkOutput($sformatf("tbl%0d_nop_pc", i), out_pc, 32'h0);
                checkOutput($sformatf("tbl%0d_nop_pc4", i), out_pc_plus4, 32'h0);
                checkOutput($sformatf("tbl%0d_nop_instr", i), out_instr, NOP_INSTR);
            end
        end

        // Asynchronous reset mid-stream with three stored entries
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(0, 1, 0, 32'h400 + 32'(i * 4), 32'h1);
        end
        @(negedge clk);
        #1;
        checkOutput("midrst_pre_count", 32'(count), 32'd3);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_out_instr", out_instr, NOP_INSTR);
        checkOutput("midrst_out_pc", out_pc, 32'h0);
        checkOutput("midrst_out_pc4", out_pc_plus4, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        #1;
        checkOutput("postrst_count", 32'(count), 32'd0);
        checkOutput("postrst_in_ready", 32'(in_ready), 32'd1);

        // Entry arriving at an empty buffer with decode ready
        @(negedge clk);
        applyStimulus(0, 1, 1, 32'h200, 32'h0000_0093);
        #1;
        checkOutput("byp_out_valid", 32'(out_valid), 32'(BYPASS));
        if (BYPASS) checkOutput("byp_out_pc", out_pc, 32'h200);
        @(negedge clk);
        applyStimulus(0, 0, 1, 32'h0, 32'h0);
        #1;
        checkOutput("byp_next_count", 32'(count), BYPASS ? 32'd0 : 32'd1);
        checkOutput("byp_next_valid", 32'(out_valid), BYPASS ? 32'd0 : 32'd1);
        if (!BYPASS) checkOutput("byp_next_pc", out_pc, 32'h200);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 32'h0);
        #1;
        checkOutput("byp_drained", 32'(count), 32'd0);

        // Randomized run against the queue model (buffer is empty here)
        model_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            inc.pc       = $urandom;
            inc.pc_plus4 = inc.pc + 32'd4;
            inc.instr    = $urandom;
            applyStimulus(($urandom_range(15) == 0), $urandom_range(1), $urandom_range(1),
                          inc.pc, inc.instr);
            #1;
            qsize  = model_q.size();
            bhit   = BYPASS && (qsize == 0) && in_valid && !flush;
            exp_ir = (qsize < DEPTH) && !flush;
            exp_ov = ((qsize > 0) && !flush) || bhit;
            checkOutput("rnd_count", 32'(count), 32'(qsize));
            checkOutput("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
            checkOutput("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
            if (bhit) begin
                checkOutput("rnd_byp_pc", out_pc, inc.pc);
            end else if (exp_ov) begin
                checkOutput("rnd_out_pc", out_pc, model_q[0].pc);
                checkOutput("rnd_out_pc4", out_pc_plus4, model_q[0].pc_plus4);
                checkOutput("rnd_out_instr", out_instr, model_q[0].instr);
            end else if (qsize == 0) begin
                checkOutput("rnd_nop_instr", out_instr, NOP_INSTR);
            end
            @(posedge clk);
            if (flush) begin
                model_q.delete();
            end else if (bhit) begin
                if (!out_ready) model_q.push_back(inc);
            end else begin
                if (exp_ov && out_ready) void'(model_q.pop_front());
                if (in_valid && exp_ir) model_q.push_back(inc);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 flush  input  1  discard all buffered and in-flight entries (branch taken in EX).
REQ-005 in_valid  input  1  fetch stage presents an entry.
REQ-006 in_ready  output  1  buffer accepts the entry this cycle.
REQ-007 in_pc, in_pc_plus4, in_instr  input  32 each  PC, PC+4 and instruction from fetch.
REQ-008 out_valid  output  1  entry available to decode.
REQ-009 out_ready  input  1  decode consumes the entry this cycle.
REQ-010 out_pc, out_pc_plus4, out_instr  output  32 each  head entry fields.
REQ-011 count  output  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-012 Push on a rising edge when in_valid && in_ready; pop on a rising edge when out_valid && out_ready.
REQ-013 Storage is a circular FIFO; read and write pointers wrap from DEPTH-1 to 0; order preserved.
REQ-014 in_ready = (count < DEPTH) && !flush && reset-deasserted; in_ready does not depend on out_ready.
REQ-015 out_valid = (count > 0) && !flush (non-bypass mode).
REQ-016 Non-bypass latency: entry pushed at edge N is visible on out_* with out_valid=1 after edge N, i.e. in cycle N+1.
REQ-017 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-018 Full (count == DEPTH): in_ready=0; a pop that cycle frees a slot, which is visible via in_ready the next cycle.
REQ-019 Empty and out_valid=0: out_instr = 32'h00000013 (NOP), out_pc = out_pc_plus4 = 0.
REQ-020 Flush is synchronous: at the edge, count and both pointers return to 0; push and pop that cycle are ignored.
REQ-021 Flush has priority over push, pop and bypass; in the flush cycle in_ready=0 and out_valid=0.
REQ-022 count never exceeds DEPTH and never underflows; a pop with count==0 is impossible because out_valid is 0.

Reset
REQ-023 While reset=0, asynchronously: count=0, pointers=0, out_valid=0, in_ready=0, out_instr=NOP, out_pc=out_pc_plus4=0.
REQ-024 Storage array contents are not reset; they are only observable after a push.
REQ-025 The first edge after reset is released behaves as an empty buffer, with in_ready=1.

Configuration
REQ-026 Macro FETCH_BUFFER_BYPASS_EN, when defined: with count==0 and in_valid=1 and flush=0, out_valid=1 and out_* = in_* combinationally.
REQ-027 In that bypass case, if out_ready=1 the entry is not written and count stays 0; otherwise the entry is written normally.
REQ-028 With FETCH_BUFFER_BYPASS_EN undefined: no combinational path from in_* to out_*; the REQ-016 latency applies.

Structure
REQ-029 Shared package fetch_pkg holds typedef fetch_entry_t {pc, pc_plus4, instr} and constant NOP_INSTR = 32'h00000013.
REQ-030 One sub-module, fetch_buffer_mem: DEPTH x fetch_entry_t register array with a write port and an async read port; no reset.

Verification
REQ-031 Reset low mid-stream with count=3 -> all outputs take their REQ-023 values immediately; after release count=0 and in_ready=1.
REQ-032 Push 0x100/0x104/0x108/0x10C with out_ready=0 -> count=4, in_ready=0; drain -> out_pc is 0x100, 0x104, 0x108, 0x10C in order.
REQ-033 DEPTH=4: 10 pushes interleaved with pops -> pointers wrap and output order matches input with no loss or duplication.
REQ-034 count=2, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0 and out_valid=0; the pushed entry is never output.
REQ-035 count=2 with push and pop on the same edge -> count stays 2 and the head advances to the second entry.
REQ-036 Bypass built, empty, in_pc=0x200, out_ready=1 -> out_valid=1 and out_pc=0x200 in the same cycle; count stays 0.
REQ-037 Bypass not built, same stimulus as REQ-036 -> out_valid=0 that cycle and out_pc=0x200 the next cycle.
